lab5_mcore_mem_port_arbiter: RTL

//  Shares one 16B main-memory request/response port between p_num_reqs cache refill

---
 rtl/lab5_mcore_mem_port_arbiter_if.sv | 38 +++
 rtl/lab5_mcore_mem_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lab5_mcore_mem_port_arbiter_if.sv
// Bus bundle between N cache refill ports and one 16B main-memory port.
//   memreq_*      : per-requester request channel (cache -> arbiter)
//   memresp_*     : per-requester response channel (arbiter -> cache)
//   mainmemreq_*  : granted request channel (arbiter -> memory)
//   mainmemresp_* : in-order response channel (memory -> arbiter)
// Modport master is the arbiter's view; slave is the surrounding system's view.
interface lab5_mcore_mem_port_arbiter_if #(
  parameter int unsigned p_num_reqs   = 4,
  parameter int unsigned p_req_nbits  = 175,
  parameter int unsigned p_resp_nbits = 145
);
  logic [p_num_reqs-1:0][p_req_nbits-1:0]  memreq_msg;
  logic [p_num_reqs-1:0]                   memreq_val;
  logic [p_num_reqs-1:0]                   memreq_rdy;
  logic [p_num_reqs-1:0][p_resp_nbits-1:0] memresp_msg;
  logic [p_num_reqs-1:0]                   memresp_val;
  logic [p_num_reqs-1:0]                   memresp_rdy;
  logic [p_req_nbits-1:0]                  mainmemreq_msg;
  logic                                    mainmemreq_val;
  logic                                    mainmemreq_rdy;
  logic [p_resp_nbits-1:0]                 mainmemresp_msg;
  logic                                    mainmemresp_val;
  logic                                    mainmemresp_rdy;

  modport master (
    input  memreq_msg, memreq_val, memresp_rdy, mainmemreq_rdy,
    input  mainmemresp_msg, mainmemresp_val,
    output memreq_rdy, memresp_msg, memresp_val,
    output mainmemreq_msg, mainmemreq_val, mainmemresp_rdy
  );

  modport slave (
    output memreq_msg, memreq_val, memresp_rdy, mainmemreq_rdy,
    output mainmemresp_msg, mainmemresp_val,
    input  memreq_rdy, memresp_msg, memresp_val,
    input  mainmemreq_msg, mainmemreq_val, mainmemresp_rdy
  );
endinterface

// File: rtl/lab5_mcore_mem_port_arbiter.sv
// Shares one main-memory port between p_num_reqs cache refill ports.
// Requests: round-robin grant, locked onto the winner while memory stalls.
// Responses: returned in order by memory, routed via a FIFO of granted IDs.
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low
//   bus             request/response channels (master modport)
//   outstanding     ID FIFO occupancy
//   err_orphan_resp sticky flag: response seen while no request was outstanding
module lab5_mcore_mem_port_arbiter #(
  parameter int unsigned p_num_reqs   = 4,
  parameter int unsigned p_req_nbits  = 175,
  parameter int unsigned p_resp_nbits = 145,
  parameter int unsigned p_max_outst  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  lab5_mcore_mem_port_arbiter_if.master  bus,
  output logic [$clog2(p_max_outst):0]   outstanding,
  output logic                           err_orphan_resp
);
  localparam int unsigned NR  = p_num_reqs;
  localparam int unsigned IDW = $clog2(p_num_reqs);
  localparam int unsigned PW  = $clog2(p_max_outst);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] locked_id_q, locked_id_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] rr_winner, rr_idx, winner, head;
  logic [CW-1:0]  wr_ptr_q, rd_ptr_q, occ;
  logic [IDW-1:0] id_fifo_q [p_max_outst];
  logic           err_q;
  logic           full, empty, req_val, req_fire, resp_rdy, resp_fire;
  logic [NR-1:0]  winner_oh, head_oh;

  // Round-robin search; descending scan leaves the nearest valid requester
  // after last_grant as the final assignment.
  always_comb begin : rr_pick
    rr_winner = last_grant_q;
    rr_idx    = last_grant_q;
    for (int k = int'(NR); k >= 1; k--) begin
      rr_idx = IDW'((int'(last_grant_q) + k) % int'(NR));
      if (bus.memreq_val[rr_idx]) rr_winner = rr_idx;
    end
  end

  // Grant, FIFO status and handshake qualifiers
  always_comb begin : grant_status
    winner    = (state_q == ARB_LOCKED) ? locked_id_q : rr_winner;
    winner_oh = NR'(1) << winner;
    occ       = wr_ptr_q - rd_ptr_q;
    full      = (occ == CW'(p_max_outst));
    empty     = (occ == '0);
    // reset gating keeps val/rdy low while reset is held, independent of inputs
    req_val   = reset & ((state_q == ARB_LOCKED) | (|bus.memreq_val)) & ~full;
    req_fire  = req_val & bus.mainmemreq_rdy;
    head      = id_fifo_q[rd_ptr_q[PW-1:0]];
    head_oh   = NR'(1) << head;
    resp_rdy  = ~empty & bus.memresp_rdy[head];
    resp_fire = bus.mainmemresp_val & resp_rdy;
  end

  // Combinational bus outputs; responses are broadcast, only head sees valid
  always_comb begin : bus_out
    bus.mainmemreq_msg  = bus.memreq_msg[winner];
    bus.mainmemreq_val  = req_val;
    bus.memreq_rdy      = (reset & bus.mainmemreq_rdy & ~full) ? winner_oh : '0;
    bus.memresp_val     = (bus.mainmemresp_val & ~empty) ? head_oh : '0;
    bus.mainmemresp_rdy = resp_rdy;
    for (int i = 0; i < int'(NR); i++) bus.memresp_msg[i] = bus.mainmemresp_msg;
  end

  assign outstanding     = occ;
  assign err_orphan_resp = err_q;

  // Grant lock: hold the winner from first stalled offer until it fires
  always_comb begin : lock_next
    state_d     = state_q;
    locked_id_d = locked_id_q;
    case (state_q)
      ARB_FREE: begin
        if (req_val && !bus.mainmemreq_rdy) begin
          state_d     = ARB_LOCKED;
          locked_id_d = winner;
        end
      end
      ARB_LOCKED: begin
        if (req_fire) state_d = ARB_FREE;
      end
      default: state_d = ARB_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : lock_reg
    if (!reset) begin
      state_q     <= ARB_FREE;
      locked_id_q <= '0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
    end
  end

  // ID FIFO, round-robin pointer and orphan flag
  always_ff @(posedge clk or negedge reset) begin : fifo_reg
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= IDW'(NR - 1);
      err_q        <= 1'b0;
      for (int i = 0; i < int'(p_max_outst); i++) id_fifo_q[i] <= '0;
    end else begin
      if (req_fire) begin
        id_fifo_q[wr_ptr_q[PW-1:0]] <= winner;
        wr_ptr_q                    <= wr_ptr_q + CW'(1);
        last_grant_q                <= winner;
      end
      if (resp_fire) rd_ptr_q <= rd_ptr_q + CW'(1);
      if (bus.mainmemresp_val && empty) err_q <= 1'b1;
    end
  end
endmodule
